// File: rtl/mem_port_pkg.sv
// Shared definitions for the off-chip memory port arbiter: state encoding,
// default bus widths and requester ids.
package mem_port_pkg;

  localparam int unsigned ADDR_W_DEF = 28;
  localparam int unsigned LINE_W_DEF = 128;
  localparam int unsigned CNT_W      = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2
  } arb_state_e;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Grants the single memory port to the I-cache or D-cache, drives one registered
// transaction at a time and routes the completion back to its owner.
module mem_port_arbiter
  import mem_port_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned LINE_W  = LINE_W_DEF,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_read,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ready,
  output logic [LINE_W-1:0] ic_rdata,
  input  logic              dc_read,
  input  logic              dc_write,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_ready,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              err
);

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              err_q, err_d;
  logic              dc_req;

  assign dc_req = dc_read | dc_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= REQ_I;
      cnt_q        <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      err_q        <= err_d;
    end
  end

  // On a conflict the side that was not granted last wins.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (dc_req && (!ic_read || last_grant_q == REQ_I)) state_d = ST_GRANT_D;
        else if (ic_read)                                 state_d = ST_GRANT_I;
      end
      ST_GRANT_I, ST_GRANT_D: begin
        if (mem_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    err_d        = err_q;
    ic_ready     = 1'b0;
    dc_ready     = 1'b0;

    if (state_q == ST_IDLE) begin
      if (mem_ready) err_d = 1'b1;
      if (state_d == ST_GRANT_I) begin
        last_grant_d = REQ_I;
        cnt_d        = '0;
        mem_read_d   = 1'b1;
        mem_write_d  = 1'b0;
        mem_addr_d   = ic_addr;
      end else if (state_d == ST_GRANT_D) begin
        // A pending writeback goes first; the read is served by a later grant.
        last_grant_d = REQ_D;
        cnt_d        = '0;
        mem_read_d   = ~dc_write;
        mem_write_d  = dc_write;
        mem_addr_d   = dc_addr;
        mem_wdata_d  = dc_wdata;
      end
    end else begin
      if (cnt_q != CNT_W'(TIMEOUT)) cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == CNT_W'(TIMEOUT)) err_d = 1'b1;
      if (mem_ready) begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        ic_ready    = ~rst & (state_q == ST_GRANT_I);
        dc_ready    = ~rst & (state_q == ST_GRANT_D);
      end
    end
  end

  assign ic_rdata  = ic_ready ? mem_rdata : '0;
  assign dc_rdata  = dc_ready ? mem_rdata : '0;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the bench plays both caches and the memory.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 28;
  localparam int unsigned LW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_read, dc_read, dc_write, mem_ready;
  logic [AW-1:0] ic_addr, dc_addr;
  logic [LW-1:0] dc_wdata, mem_rdata;
  logic          ic_ready, dc_ready, mem_read, mem_write, err;
  logic [LW-1:0] ic_rdata, dc_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  int total = 0;
  int bad   = 0;

  localparam logic [LW-1:0] PAT_A = {32{4'hA}};
  localparam logic [LW-1:0] PAT_B = {32{4'h5}};
  localparam logic [LW-1:0] PAT_W = {8{16'h1234}};
  localparam logic [LW-1:0] PAT_C = {4{32'hCAFE_F00D}};

  mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .ic_read(ic_read), .ic_addr(ic_addr), .ic_ready(ic_ready), .ic_rdata(ic_rdata),
    .dc_read(dc_read), .dc_write(dc_write), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_ready(dc_ready), .dc_rdata(dc_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_mrd"}, LW'(mem_read), '0);
    chk({tag, "_mwr"}, LW'(mem_write), '0);
    chk({tag, "_ird"}, LW'(ic_ready), '0);
    chk({tag, "_drd"}, LW'(dc_ready), '0);
  endtask

  initial begin
    rst = 1'b1; ic_read = 0; dc_read = 0; dc_write = 0; mem_ready = 0;
    ic_addr = '0; dc_addr = '0; dc_wdata = '0; mem_rdata = '0;
    tick(); tick();
    #1;
    chk_idle_outs("rst");
    chk("rst_err", LW'(err), '0);
    chk("rst_addr", LW'(mem_addr), '0);
    chk("rst_wdata", mem_wdata, '0);
    chk("rst_irdata", ic_rdata, '0);

    // I only, memory answers in the third command cycle
    tick(); rst = 0; ic_read = 1; ic_addr = 28'h0000010; #1;
    chk("i_t0_mrd", LW'(mem_read), '0);
    tick(); #1;
    chk("i_t1_mrd", LW'(mem_read), 1);
    chk("i_t1_addr", LW'(mem_addr), 28'h0000010);
    chk("i_t1_mwr", LW'(mem_write), '0);
    tick(); #1;
    chk("i_t2_ird", LW'(ic_ready), '0);
    chk("i_t2_drd", LW'(dc_ready), '0);
    tick(); mem_ready = 1; mem_rdata = PAT_A; #1;
    chk("i_t3_ird", LW'(ic_ready), 1);
    chk("i_t3_data", ic_rdata, PAT_A);
    chk("i_t3_drd", LW'(dc_ready), '0);
    chk("i_t3_drdata", dc_rdata, '0);
    tick(); mem_ready = 0; ic_read = 0; #1;
    chk_idle_outs("i_t4");
    chk("i_t4_irdata", ic_rdata, '0);

    // Simultaneous requests after reset: D, one IDLE cycle, I, then D again
    rst = 1; tick(); rst = 0;
    ic_read = 1; dc_read = 1; ic_addr = 28'h20; dc_addr = 28'h30; #1;
    tick(); mem_ready = 1; mem_rdata = PAT_B; #1;
    chk("rr1_mrd", LW'(mem_read), 1);
    chk("rr1_addr", LW'(mem_addr), 28'h30);
    chk("rr1_drd", LW'(dc_ready), 1);
    chk("rr1_ddata", dc_rdata, PAT_B);
    chk("rr1_ird", LW'(ic_ready), '0);
    chk("rr1_idata", ic_rdata, '0);
    tick(); mem_ready = 0; dc_read = 0; #1;
    chk("rr_idle_mrd", LW'(mem_read), '0);
    tick(); dc_read = 1; mem_ready = 1; mem_rdata = PAT_A; #1;
    chk("rr2_mrd", LW'(mem_read), 1);
    chk("rr2_addr", LW'(mem_addr), 28'h20);
    chk("rr2_ird", LW'(ic_ready), 1);
    chk("rr2_drd", LW'(dc_ready), '0);
    tick(); mem_ready = 0; #1;
    chk("rr_idle2_mrd", LW'(mem_read), '0);
    tick(); mem_ready = 1; mem_rdata = PAT_C; #1;
    chk("rr3_addr", LW'(mem_addr), 28'h30);
    chk("rr3_drd", LW'(dc_ready), 1);
    chk("rr3_ddata", dc_rdata, PAT_C);
    tick(); mem_ready = 0; ic_read = 0; dc_read = 0; #1;

    // D write and read together: write first, read as a second transaction
    tick(); dc_write = 1; dc_read = 1; dc_addr = 28'h40; dc_wdata = PAT_W; #1;
    tick(); #1;
    chk("wr_mwr", LW'(mem_write), 1);
    chk("wr_mrd", LW'(mem_read), '0);
    chk("wr_wdata", mem_wdata, PAT_W);
    chk("wr_addr", LW'(mem_addr), 28'h40);
    tick(); mem_ready = 1; mem_rdata = '0; #1;
    chk("wr_drd", LW'(dc_ready), 1);
    tick(); mem_ready = 0; dc_write = 0; #1;
    chk("wr_idle_mwr", LW'(mem_write), '0);
    chk("wr_idle_mrd", LW'(mem_read), '0);
    tick(); mem_ready = 1; mem_rdata = PAT_B; #1;
    chk("wrd_mrd", LW'(mem_read), 1);
    chk("wrd_mwr", LW'(mem_write), '0);
    chk("wrd_ddata", dc_rdata, PAT_B);
    tick(); mem_ready = 0; dc_read = 0; #1;

    // Requester changes during GRANT_I have no effect
    tick(); ic_read = 1; ic_addr = 28'h50; #1;
    tick(); dc_addr = 28'h99; dc_write = 1; dc_wdata = PAT_C; #1;
    chk("mid_addr1", LW'(mem_addr), 28'h50);
    tick(); #1;
    chk("mid_addr2", LW'(mem_addr), 28'h50);
    chk("mid_mwr", LW'(mem_write), '0);
    tick(); mem_ready = 1; mem_rdata = PAT_A; #1;
    chk("mid_ird", LW'(ic_ready), 1);
    chk("mid_addr3", LW'(mem_addr), 28'h50);
    tick(); mem_ready = 0; ic_read = 0; #1;
    chk("mid_idle_mrd", LW'(mem_read), '0);
    tick(); #1;
    chk("mid_d_mwr", LW'(mem_write), 1);
    chk("mid_d_addr", LW'(mem_addr), 28'h99);
    mem_ready = 1; #1;
    tick(); mem_ready = 0; dc_write = 0; #1;

    // Watchdog: no response for 8 cycles after the first command cycle
    tick(); ic_read = 1; ic_addr = 28'h60; #1;
    tick(); #1;
    chk("wd_g0_err", LW'(err), '0);
    for (int i = 1; i < 8; i++) tick();
    #1;
    chk("wd_g7_err", LW'(err), '0);
    tick(); #1;
    chk("wd_g8_err", LW'(err), 1);
    chk("wd_g8_mrd", LW'(mem_read), 1);
    tick(); mem_ready = 1; mem_rdata = PAT_C; #1;
    chk("wd_late_ird", LW'(ic_ready), 1);
    tick(); mem_ready = 0; ic_read = 0; #1;
    chk("wd_after_err", LW'(err), 1);
    chk("wd_after_mrd", LW'(mem_read), '0);
    rst = 1; tick(); rst = 0; #1;
    chk_idle_outs("wd_rst");
    chk("wd_rst_err", LW'(err), '0);
    chk("wd_rst_addr", LW'(mem_addr), '0);
    chk("wd_rst_wdata", mem_wdata, '0);

    // Stray completion while IDLE
    tick(); mem_ready = 1; #1;
    chk("stray_ird", LW'(ic_ready), '0);
    tick(); mem_ready = 0; #1;
    chk("stray_err", LW'(err), 1);
    rst = 1; tick(); rst = 0; #1;
    chk("stray_rst_err", LW'(err), '0);

    // Reset during GRANT_D drops the write with no ready pulse
    tick(); dc_write = 1; dc_addr = 28'h70; dc_wdata = PAT_W; #1;
    tick(); #1;
    chk("rmid_mwr", LW'(mem_write), 1);
    rst = 1; mem_ready = 1; #1;
    chk("rmid_drd", LW'(dc_ready), '0);
    tick(); rst = 0; mem_ready = 0; dc_write = 0; ic_read = 1; ic_addr = 28'h71; #1;
    chk("rmid_after_mwr", LW'(mem_write), '0);
    chk("rmid_after_addr", LW'(mem_addr), '0);
    tick(); #1;
    chk("rmid_regrant_mrd", LW'(mem_read), 1);
    chk("rmid_regrant_addr", LW'(mem_addr), 28'h71);
    chk("rmid_err", LW'(err), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single off-chip memory port between the I-cache refill path and the D-cache refill/writeback path of the five-stage pipeline core. Each cache raises a level request on miss or dirty eviction. The arbiter grants one requester at a time, drives one registered memory transaction, and routes the completion and read line back to the owner. It sits between the two caches and the memory model, below the pipeline's cache interfaces.

## Interface
- `ADDR_W`, 28: line address width (byte address >> 4).
- `LINE_W`, 128: cache line width in bits.
- `TIMEOUT`, 1023: maximum cycles a memory transaction may stay outstanding before `err` is set.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ic_read` in 1: I-cache line read request, level; held until `ic_ready`.
- `ic_addr` in ADDR_W: I-cache line address.
- `ic_ready` out 1: one-cycle completion pulse to the I-cache.
- `ic_rdata` out LINE_W: read line; valid only while `ic_ready`=1.
- `dc_read` in 1: D-cache line read request, level.
- `dc_write` in 1: D-cache writeback request, level.
- `dc_addr` in ADDR_W: D-cache line address.
- `dc_wdata` in LINE_W: D-cache writeback line.
- `dc_ready` out 1: one-cycle completion pulse to the D-cache.
- `dc_rdata` out LINE_W: read line; valid only while `dc_ready`=1.
- `mem_read` out 1: memory read command, registered.
- `mem_write` out 1: memory write command, registered; never high together with `mem_read`.
- `mem_addr` out ADDR_W: registered address.
- `mem_wdata` out LINE_W: registered write line.
- `mem_ready` in 1: memory completion pulse; carries `mem_rdata` for reads.
- `mem_rdata` in LINE_W: memory read line.
- `err` out 1: sticky timeout flag, cleared only by `rst`.

## Operation
- FSM states:
  - IDLE: no grant.
  - GRANT_I: I-cache read outstanding.
  - GRANT_D: D-cache read or write outstanding.
- Arbitration in IDLE:
  - Only one side requesting: that side wins.
  - Both sides requesting: round-robin on `last_grant`. The side not granted last wins.
  - `last_grant` resets to I, so the D side wins the first conflict.
- D-side op select at grant: if `dc_write`=1, the transaction is a write, even when `dc_read`=1 too. The read stays pending and is served as a separate later transaction.
- At the grant edge:
  - latch address and write data into the `mem_*` registers;
  - set exactly one of `mem_read`/`mem_write`;
  - update `last_grant`.
- In GRANT_x, when `mem_ready`=1:
  - combinationally assert `x_ready` for that cycle, with `x_rdata` = `mem_rdata`;
  - at the edge, clear `mem_read`/`mem_write` and return to IDLE.
- The non-owner's ready is always 0. Both rdata outputs are 0 when their ready is 0.
- Requester inputs are ignored outside IDLE. Address and data changes mid-transaction have no effect.
- Watchdog:
  - 10-bit counter, cleared on every grant, increments each cycle in GRANT_x.
  - When it reaches TIMEOUT, `err` is set.
  - The transaction continues to wait for `mem_ready`; there is no abort.
- A `mem_ready` received in IDLE is ignored, and `err` is set.

## Timing
- Reset values:
  - state IDLE, `last_grant`=I, counter 0;
  - `mem_read`, `mem_write`, `ic_ready`, `dc_ready`, `err` = 0;
  - `mem_addr`, `mem_wdata`, both rdata = 0.
- Reset mid-transaction drops the commands on the next edge. The memory is reset by the same `rst`.
- Cycle timing:
  - Request high in IDLE in cycle t: command visible in cycle t+1.
  - `mem_ready` in cycle r: `x_ready` in cycle r (0 added latency). Back in IDLE in cycle r+1.
- Requester deasserts its request in r+1, so IDLE never re-grants a completed request.
- Minimum spacing between two transactions is 2 cycles: one IDLE cycle plus the command cycle.
- Starvation bound: with both sides requesting continuously, grants alternate I/D.

## Structure
- Shared package `mem_port_pkg`:
  - state encoding, 2 bits: IDLE=0, GRANT_I=1, GRANT_D=2;
  - the `ADDR_W`/`LINE_W` defaults;
  - the requester id constants, used by the cache and top-level blocks.
- Single module. The watchdog counter stays inline; no sub-module.

## Test plan
- I only: `ic_read`=1, `ic_addr`=0x0000010. Memory returns 0xAAAA…AAAA with 3-cycle latency. Required:
  - `mem_read`=1 and `mem_addr`=0x0000010 from t+1;
  - `ic_ready` pulse with that data;
  - `dc_ready`=0 throughout.
- Simultaneous request after reset: `ic_read` and `dc_read` both high. Required:
  - D granted first;
  - then I granted after exactly one IDLE cycle;
  - then, if both are still requesting, D again.
- D write+read together: `dc_write`=`dc_read`=1, `dc_wdata`=0x1234…. Required:
  - `mem_write`=1 with that data first, `mem_read`=0;
  - after `dc_ready`, a second transaction with `mem_read`=1.
- Request changes mid-transaction: during GRANT_I, toggle `dc_addr` and raise `dc_write`. Required: `mem_addr` unchanged until I completes.
- Watchdog: TIMEOUT=8, memory never responds. Required:
  - `err`=1 at grant+8;
  - `err` stays 1 after a late `mem_ready`;
  - `rst` clears `err` and all outputs.
- Reset mid-transaction: assert `rst` one cycle during GRANT_D. Required: `mem_write`=0 and state IDLE next cycle, and no ready pulse.
